tick_gen_multi: RTL and testbench

- Parametrised multi-channel clock-enable generator; successor to the lab3 fixed-rate divider (1 Hz, 2 Hz, fast-scan, blink).
- Produces NUM_CH independent one-cycle tick pulses from the 100 MHz master clock. Each channel has its own compile-time divisor.
- Adds run-time global enable, a per-channel pause mask and a phase resync.
- Sits between the board clock and the stopwatch counter, display mux and blink logic. All downstream logic stays on clk and uses ticks as enables; no derived clocks.

---
 rtl/tick_gen_multi.sv | 125 ++++++++++++
 tb/tb_tick_gen_multi.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_gen_multi.sv
// -----------------------------------------------------------------------------
// tick_gen_multi
//
// Multi-channel clock-enable generator. Each of NUM_CH channels divides the
// master clock by its own compile-time divisor and emits a registered,
// one-cycle tick pulse. Downstream logic stays on clk and uses the ticks as
// enables, so there are no derived clocks.
//
// Run-time controls:
//   - en     : global run; low freezes every channel counter.
//   - pause  : per-channel hold; bit i high freezes channel i.
//   - resync : single-cycle request that zeroes all counters so every channel
//              restarts from the same phase.
// Edge priority: rst > resync > (en & ~pause[i]) > hold.
//
// Optional feature (macro TICK_GEN_SQUARE_EN):
//   Defined   : sq[i] toggles whenever tick[i] is set, giving a 50 % duty
//               square wave at f_clk / (2 * D_i). Cleared by rst and resync,
//               holds its level while the channel is held.
//   Undefined : sq is tied to 0 and no toggle flops exist.
//
// There is no valid/ready handshake on this block: en, pause and resync are
// level/pulse controls sampled on every rising edge, and tick/sq are
// free-running registered outputs with no back-pressure.
//
// Parameters:
//   NUM_CH : number of tick channels (1..16)
//   CNT_W  : width of each channel counter
//   DIVS   : packed NUM_CH x 32 divisor vector, channel i uses DIVS[32*i +: 32].
//            Divisors below 2 are clamped to 1 (tick on every active cycle).
//            A divisor above 2^CNT_W is an elaboration error.
//
// Ports:
//   clk    in  1       master clock, rising edge
//   rst    in  1       synchronous active-high reset
//   en     in  1       global run
//   pause  in  NUM_CH  per-channel hold
//   resync in  1       phase realign request
//   tick   out NUM_CH  one-cycle enable pulse per channel (registered)
//   sq     out NUM_CH  square wave per channel (0 unless TICK_GEN_SQUARE_EN)
// -----------------------------------------------------------------------------
module tick_gen_multi #(
  parameter int                      NUM_CH = 4,
  parameter int                      CNT_W  = 27,
  parameter logic [NUM_CH*32-1:0]    DIVS   = {32'd66_666_667, 32'd1_666_667,
                                               32'd50_000_000, 32'd100_000_000}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] pause,
  input  logic              resync,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("tick_gen_multi: NUM_CH must be in 1..16");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [31:0] DIV_RAW = DIVS[32*i +: 32];

    // Terminal count D_i - 1. Divisors 0 and 1 both collapse to D_i = 1,
    // which leaves the counter parked at 0 and ticks every active cycle.
    localparam logic [CNT_W-1:0] TERM =
      (DIV_RAW < 32'd2) ? '0 : CNT_W'(DIV_RAW - 32'd1);

    // D_i - 1 must be representable in CNT_W bits.
    if (64'(DIV_RAW) > (64'd1 << CNT_W)) begin : g_div_too_big
      $error("tick_gen_multi: divisor of channel %0d exceeds 2^CNT_W", i);
    end

    logic [CNT_W-1:0] cnt;
    logic             tick_q;
    logic             active;

    assign active = en & ~pause[i];

    // Wrap is an explicit compare against TERM, never counter overflow.
    // A held channel keeps its count, so a wrap blocked by pause or en=0
    // fires on the first active edge afterwards.
    always_ff @(posedge clk) begin
      if (rst || resync) begin
        cnt    <= '0;
        tick_q <= 1'b0;
      end else if (active) begin
        if (cnt == TERM) begin
          cnt    <= '0;
          tick_q <= 1'b1;
        end else begin
          cnt    <= cnt + CNT_ONE;
          tick_q <= 1'b0;
        end
      end else begin
        tick_q <= 1'b0;
      end
    end

    assign tick[i] = tick_q;

`ifdef TICK_GEN_SQUARE_EN
    logic sq_q;

    // Toggles on exactly the edges that raise tick_q, so one full sq period
    // spans two tick periods.
    always_ff @(posedge clk) begin
      if (rst || resync) begin
        sq_q <= 1'b0;
      end else if (active && (cnt == TERM)) begin
        sq_q <= ~sq_q;
      end
    end

    assign sq[i] = sq_q;
`endif
  end

`ifndef TICK_GEN_SQUARE_EN
  assign sq = '0;
`endif

endmodule

// File: tb/tb_tick_gen_multi.sv
// -----------------------------------------------------------------------------
// tb_tick_gen_multi
//
// Directed bench for tick_gen_multi with small divisors: ch0 D=5, ch1 D=3,
// ch2 D=2, ch3 D=1. Cycle n means the value sampled 1 time unit after the
// n-th rising edge following reset release. Expected tick schedules are
// hand-written per scenario with mark(); expected sq is the running parity
// of expected ticks (cleared by rst/resync) when TICK_GEN_SQUARE_EN is
// defined, and 0 otherwise.
// -----------------------------------------------------------------------------
module tb_tick_gen_multi;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

`ifdef TICK_GEN_SQUARE_EN
  localparam bit SQ_ON = 1'b1;
`else
  localparam bit SQ_ON = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              en;
  logic [NUM_CH-1:0] pause;
  logic              resync;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;

  int passed;
  int total;

  logic [NUM_CH-1:0] exp_tk [0:31];
  logic [NUM_CH-1:0] esq;

  tick_gen_multi #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .DIVS   ({32'd1, 32'd2, 32'd3, 32'd5})
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .pause  (pause),
    .resync (resync),
    .tick   (tick),
    .sq     (sq)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic clear_exp();
    for (int n = 0; n < 32; n++) exp_tk[n] = '0;
  endtask

  task automatic mark(input int ch, input int first, input int stp, input int last);
    for (int n = first; n <= last; n += stp) exp_tk[n][ch] = 1'b1;
  endtask

  task automatic apply_reset();
    rst    = 1'b1;
    en     = 1'b0;
    pause  = '0;
    resync = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    esq = '0;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    en     = 1'b1;
    pause  = '0;
    resync = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      @(posedge clk);
      #1;
      total++;
      if (tick !== 4'b0000) $display("FAIL reset tick edge %0d: got %b, expected 0000", n, tick);
      else passed++;
      total++;
      if (sq !== 4'b0000) $display("FAIL reset sq edge %0d: got %b, expected 0000", n, sq);
      else passed++;
    end
    rst = 1'b0;
    en  = 1'b0;
  endtask

  task automatic test_basic();
    clear_exp();
    mark(0, 5, 5, 15);
    mark(1, 3, 3, 15);
    mark(2, 2, 2, 14);
    mark(3, 1, 1, 15);
    apply_reset();
    en = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      @(posedge clk);
      #1;
      esq = SQ_ON ? (esq ^ exp_tk[n]) : '0;
      total++;
      if (tick !== exp_tk[n]) $display("FAIL basic tick cycle %0d: got %b, expected %b", n, tick, exp_tk[n]);
      else passed++;
      total++;
      if (sq !== esq) $display("FAIL basic sq cycle %0d: got %b, expected %b", n, sq, esq);
      else passed++;
    end
  endtask

  // ch0 paused on edges 3..8 (counter frozen at 2); ch1 paused on edges 3..4,
  // edge 3 being the edge its wrap was due.
  task automatic test_pause();
    clear_exp();
    mark(0, 11, 5, 16);
    mark(1, 5, 3, 14);
    mark(2, 2, 2, 16);
    mark(3, 1, 1, 16);
    apply_reset();
    en = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      pause[0] = (n >= 3 && n <= 8);
      pause[1] = (n >= 3 && n <= 4);
      @(posedge clk);
      #1;
      esq = SQ_ON ? (esq ^ exp_tk[n]) : '0;
      total++;
      if (tick !== exp_tk[n]) $display("FAIL pause tick cycle %0d: got %b, expected %b", n, tick, exp_tk[n]);
      else passed++;
      total++;
      if (sq !== esq) $display("FAIL pause sq cycle %0d: got %b, expected %b", n, sq, esq);
      else passed++;
    end
    pause = '0;
  endtask

  // en low on edges 4..7 shifts every later tick by 4 cycles.
  task automatic test_en_gap();
    clear_exp();
    mark(0, 9, 5, 14);
    mark(1, 3, 3, 3);
    mark(1, 10, 3, 16);
    mark(2, 2, 2, 2);
    mark(2, 8, 2, 16);
    mark(3, 1, 1, 3);
    mark(3, 8, 1, 16);
    apply_reset();
    for (int n = 1; n <= 16; n++) begin
      en = !(n >= 4 && n <= 7);
      @(posedge clk);
      #1;
      esq = SQ_ON ? (esq ^ exp_tk[n]) : '0;
      total++;
      if (tick !== exp_tk[n]) $display("FAIL en_gap tick cycle %0d: got %b, expected %b", n, tick, exp_tk[n]);
      else passed++;
      total++;
      if (sq !== esq) $display("FAIL en_gap sq cycle %0d: got %b, expected %b", n, sq, esq);
      else passed++;
    end
  endtask

  // resync sampled on edge 8: all ticks 0 on cycle 8, then first ticks at 8+D.
  task automatic test_resync();
    clear_exp();
    mark(0, 5, 5, 5);
    mark(0, 13, 5, 18);
    mark(1, 3, 3, 6);
    mark(1, 11, 3, 17);
    mark(2, 2, 2, 6);
    mark(2, 10, 2, 18);
    mark(3, 1, 1, 7);
    mark(3, 9, 1, 18);
    apply_reset();
    en = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      resync = (n == 8);
      @(posedge clk);
      #1;
      if (n == 8) esq = '0;
      else esq = SQ_ON ? (esq ^ exp_tk[n]) : '0;
      total++;
      if (tick !== exp_tk[n]) $display("FAIL resync tick cycle %0d: got %b, expected %b", n, tick, exp_tk[n]);
      else passed++;
      total++;
      if (sq !== esq) $display("FAIL resync sq cycle %0d: got %b, expected %b", n, sq, esq);
      else passed++;
    end
    resync = 1'b0;
  endtask

  // rst on edge 5 with ch0 at count 4 (wrap pending): no ch0 tick, next ch0
  // tick 5 active edges later at cycle 10.
  task automatic test_rst_midcount();
    clear_exp();
    mark(0, 10, 5, 10);
    mark(1, 3, 3, 3);
    mark(1, 8, 3, 11);
    mark(2, 2, 2, 4);
    mark(2, 7, 2, 11);
    mark(3, 1, 1, 4);
    mark(3, 6, 1, 11);
    apply_reset();
    en = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      rst = (n == 5);
      @(posedge clk);
      #1;
      if (n == 5) esq = '0;
      else esq = SQ_ON ? (esq ^ exp_tk[n]) : '0;
      total++;
      if (tick !== exp_tk[n]) $display("FAIL rst_mid tick cycle %0d: got %b, expected %b", n, tick, exp_tk[n]);
      else passed++;
      total++;
      if (sq !== esq) $display("FAIL rst_mid sq cycle %0d: got %b, expected %b", n, sq, esq);
      else passed++;
    end
    rst = 1'b0;
  endtask

  // Sequencer and final report
  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    en     = 1'b0;
    pause  = '0;
    resync = 1'b0;
    esq    = '0;
    clear_exp();

    test_reset();
    test_basic();
    test_pause();
    test_en_gap();
    test_resync();
    test_rst_midcount();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
